// File: rtl/pe_array_pkg.sv
// pe_array_pkg: defaults shared with the PE-array wrapper, feeder state encoding and a clog2 helper.
package pe_array_pkg;

    localparam int KERNEL_SIZE_DEF = 3;
    localparam int DATA_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } feeder_state_t;

    // Never returns 0 so a one-entry dimension still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pe_line_buffer.sv
// pe_line_buffer: one image row of pixels as a shift register; shifts on en, data is never reset.
module pe_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
        end
    end

    assign dout = r_mem[DEPTH-1];

endmodule

// File: rtl/pe_window_feeder.sv
// pe_window_feeder: raster pixel stream -> per-cycle KERNEL_SIZE-row column vector for the PE array.
// Define PE_FEEDER_ZERO_PAD_EN to skip the fill phase and zero the rows above the image instead.
module pe_window_feeder
    import pe_array_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    localparam int RW = clog2(IMG_HEIGHT),
    localparam int CW = clog2(IMG_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_pixel,
    input  logic                              pe_stall,
    output logic                              pe_en,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] pe_dataIn,
    output logic                              win_valid,
    output logic [RW-1:0]                     row_idx,
    output logic [CW-1:0]                     col_idx,
    output logic                              busy,
    output logic                              frame_done
);

`ifdef PE_FEEDER_ZERO_PAD_EN
    localparam bit            ZERO_PAD = 1'b1;
    localparam feeder_state_t START_ST = ST_STREAM;
`else
    localparam bit            ZERO_PAD = 1'b0;
    localparam feeder_state_t START_ST = ST_FILL;
`endif

    feeder_state_t r_state, w_next;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic w_accept, w_emit, w_last_col;
    logic [DATA_WIDTH-1:0] w_tap [KERNEL_SIZE];
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] w_vec;
    logic r_pe_en, r_win_valid;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] r_data;
    logic [RW-1:0] r_row_idx;
    logic [CW-1:0] r_col_idx;

    assign w_accept   = s_valid && s_ready;
    assign w_emit     = w_accept && r_state == ST_STREAM;
    assign w_last_col = r_col == CW'(IMG_WIDTH - 1);

    always_ff @(posedge clk) begin
        r_state <= !rstn ? ST_IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = start ? START_ST : ST_IDLE;
            ST_FILL:   w_next = (w_accept && w_last_col && r_row == RW'(KERNEL_SIZE - 2)) ? ST_STREAM : ST_FILL;
            ST_STREAM: w_next = (w_accept && w_last_col && r_row == RW'(IMG_HEIGHT - 1)) ? ST_DONE : ST_STREAM;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready    = (r_state == ST_FILL || r_state == ST_STREAM) && !pe_stall;
        busy       = r_state != ST_IDLE;
        frame_done = r_state == ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) r_row <= (r_row == RW'(IMG_HEIGHT - 1)) ? '0 : r_row + 1'b1;
        end
    end

    // Tap k is the pixel k rows above the incoming one, same column.
    assign w_tap[0] = s_pixel;
    for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_lb
        pe_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_lb (
            .clk  (clk),
            .en   (w_accept),
            .din  (w_tap[k]),
            .dout (w_tap[k+1])
        );
    end

    // With zero padding, rows above the image are masked by the row counter, not cleared in memory.
    always_comb begin
        w_vec = '0;
        for (int k = 0; k < KERNEL_SIZE; k++)
            w_vec[k*DATA_WIDTH +: DATA_WIDTH] = (ZERO_PAD && int'(r_row) < k) ? '0 : w_tap[k];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pe_en     <= 1'b0;
            r_win_valid <= 1'b0;
            r_data      <= '0;
            r_row_idx   <= '0;
            r_col_idx   <= '0;
        end else begin
            r_pe_en     <= w_emit;
            r_win_valid <= w_emit && int'(r_col) >= KERNEL_SIZE - 1;
            if (w_emit) begin
                r_data    <= w_vec;
                r_row_idx <= r_row;
                r_col_idx <= r_col;
            end
        end
    end

    assign pe_en     = r_pe_en;
    assign win_valid = r_win_valid;
    assign pe_dataIn = r_data;
    assign row_idx   = r_row_idx;
    assign col_idx   = r_col_idx;

endmodule

// File: tb/tb_pe_window_feeder.sv
// tb_pe_window_feeder: scoreboard bench; driver pushes expected column vectors, monitor pops on pe_en.
module tb_pe_window_feeder;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
`ifdef PE_FEEDER_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    typedef struct {
        logic [K*DW-1:0] d;
        logic [1:0]      r;
        logic [1:0]      c;
        logic            w;
    } exp_t;

    logic clk, rstn, start, s_valid, s_ready, pe_stall, pe_en, win_valid, busy, frame_done;
    logic [DW-1:0]   s_pixel;
    logic [K*DW-1:0] pe_dataIn;
    logic [1:0]      row_idx, col_idx;

    exp_t q[$];
    int n_chk, n_fail, done_cnt;

    pe_window_feeder #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_pixel    (s_pixel),
        .pe_stall   (pe_stall),
        .pe_en      (pe_en),
        .pe_dataIn  (pe_dataIn),
        .win_valid  (win_valid),
        .row_idx    (row_idx),
        .col_idx    (col_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slice k is pixel (r-k, c) = (r-k)*16 + c; rows above the image read as zero.
    function automatic logic [K*DW-1:0] exp_vec(input int r, input int c);
        logic [K*DW-1:0] v;
        v = '0;
        for (int k = 0; k < K; k++)
            if (r - k >= 0) v[k*DW +: DW] = DW'((r - k) * 16 + c);
        return v;
    endfunction

    always @(negedge clk) begin
        if (pe_en) begin
            if (q.size() == 0) begin
                chk("unexpected_pe_en", {40'd0, pe_dataIn}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pe_dataIn", {40'd0, pe_dataIn}, {40'd0, e.d});
                chk("row_idx", {62'd0, row_idx}, {62'd0, e.r});
                chk("col_idx", {62'd0, col_idx}, {62'd0, e.c});
                chk("win_valid", {63'd0, win_valid}, {63'd0, e.w});
            end
        end
        if (frame_done) done_cnt++;
    end

    task automatic feed(input int n, input int stall_idx, input int start_idx);
        for (int i = 0; i < n; i++) begin
            int r, c, t;
            r = i / W;
            c = i % W;
            s_pixel = DW'(r * 16 + c);
            s_valid = 1'b1;
            if (i == start_idx) start = 1'b1;
            if (i == stall_idx) begin
                pe_stall = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_s_ready", {63'd0, s_ready}, 64'd0);
                    if (j > 0) begin
                        chk("stall_pe_en", {63'd0, pe_en}, 64'd0);
                        chk("stall_hold", {40'd0, pe_dataIn}, {40'd0, exp_vec((i - 1) / W, (i - 1) % W)});
                    end
                end
                pe_stall = 1'b0;
            end
            #1;
            t = 0;
            while (!s_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) chk("accept_timeout", 64'd0, 64'd1);
            if (ZP || r >= K - 1) q.push_back('{exp_vec(r, c), 2'(r), 2'(c), c >= K - 1});
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic frame_end(input int done_exp);
        chk("frame_done_pulse", {63'd0, frame_done}, 64'd1);
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        chk("frame_done_single", {63'd0, frame_done}, 64'd0);
        chk("busy_fall", {63'd0, busy}, 64'd0);
        chk("idle_s_ready", {63'd0, s_ready}, 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(done_exp));
    endtask

    task automatic chk_zero(input string name);
        chk(name, {pe_en, win_valid, busy, frame_done, s_ready, row_idx, col_idx, pe_dataIn}, 64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        done_cnt = 0;
        rstn = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_pixel = '0;
        pe_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_outputs");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_s_ready_after_reset", {63'd0, s_ready}, 64'd0);
        pulse_start();
        feed(W * H, 13, 5);
        frame_end(1);
        pulse_start();
        feed(10, -1, -1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("midframe_reset_outputs");
        rstn = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt), 64'd1);
        pulse_start();
        feed(W * H, -1, -1);
        frame_end(2);
        repeat (3) @(posedge clk);
        #1;
        chk("final_done_count", 64'(done_cnt), 64'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
